// File: rtl/rr_bus_arbiter_if.sv
// Shared-bus bundle between N requesting masters, the arbiter and a single slave.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface rr_bus_arbiter_if #(
  parameter int unsigned MASTER_CNT = 4
);
  logic [MASTER_CNT-1:0]    m_valid;
  logic [32*MASTER_CNT-1:0] m_addr;
  logic [32*MASTER_CNT-1:0] m_wdata;
  logic [4*MASTER_CNT-1:0]  m_wstrb;
  logic [MASTER_CNT-1:0]    m_ready;
  logic [32*MASTER_CNT-1:0] m_rdata;
  logic                     s_valid;
  logic [31:0]              s_addr;
  logic [31:0]              s_wdata;
  logic [3:0]               s_wstrb;
  logic                     s_ready;
  logic [31:0]              s_rdata;

  modport master (
    input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
  );

  modport slave (
    output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    input  m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
  );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter granting one of MASTER_CNT masters access to a single slave,
// with an optional slave-wait timeout that completes the transfer with error data.
module rr_bus_arbiter #(
  parameter int unsigned MASTER_CNT  = 4,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_RDATA   = 32'hDEADBEEF
) (
  input  logic             clk,
  input  logic             resetn,
  rr_bus_arbiter_if.master bus,
  output logic [31:0]      currmaster,
  output logic             timeout_err
);
  localparam int unsigned IdxW = (MASTER_CNT > 1) ? $clog2(MASTER_CNT) : 1;
  localparam int unsigned CntW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            sel_valid;
  logic [31:0]     sel_addr, sel_wdata;
  logic [3:0]      sel_wstrb;
  logic [IdxW-1:0] rr_pick;
  logic            done, timeout_hit;

  // Request fields of the granted master.
  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < MASTER_CNT; i++) begin
      if (gnt_q == IdxW'(i)) begin
        sel_valid = bus.m_valid[i];
        sel_addr  = bus.m_addr[32*i +: 32];
        sel_wdata = bus.m_wdata[32*i +: 32];
        sel_wstrb = bus.m_wstrb[4*i +: 4];
      end
    end
  end

  // First requester at or after last+1, wrapping around.
  always_comb begin
    logic            found;
    logic [IdxW-1:0] cand;
    rr_pick = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= MASTER_CNT; k++) begin
      cand = IdxW'((int'(last_q) + k) % MASTER_CNT);
      if (!found && bus.m_valid[cand]) begin
        found   = 1'b1;
        rr_pick = cand;
      end
    end
  end

  assign done        = (state_q == StBusy) && sel_valid && bus.s_ready;
  // s_ready wins over a coincident timeout.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (state_q == StBusy) && sel_valid &&
                       !bus.s_ready && (cnt_q == CntW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      last_q  <= IdxW'(MASTER_CNT - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (|bus.m_valid) begin
          gnt_d   = rr_pick;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!sel_valid) begin
          state_d = StIdle;
        end else if (done || timeout_hit) begin
          last_d  = gnt_q;
          state_d = StIdle;
        end else if (TIMEOUT_CYC != 0) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.s_valid = 1'b0;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    bus.s_wstrb = '0;
    bus.m_ready = '0;
    bus.m_rdata = '0;
    timeout_err = 1'b0;
    currmaster  = 32'(gnt_q);
    if (state_q == StBusy) begin
      bus.s_valid = sel_valid && !timeout_hit;
      bus.s_addr  = sel_addr;
      bus.s_wdata = sel_wdata;
      bus.s_wstrb = sel_wstrb;
      timeout_err = timeout_hit;
      for (int i = 0; i < MASTER_CNT; i++) begin
        if (gnt_q == IdxW'(i)) begin
          bus.m_rdata[32*i +: 32] = timeout_hit ? ERR_RDATA : bus.s_rdata;
          bus.m_ready[i]          = done || timeout_hit;
        end
      end
    end
  end
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter: a cycle-level behavioural model checked every
// cycle on the falling edge, plus literal expectations for each directed scenario.
module tb_rr_bus_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] currmaster;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;
  int served[$];

  // Behavioural model state: who holds the bus, who was served last, cycles waited.
  bit mbusy = 1'b0;
  int mg    = 0;
  int mlast = N - 1;
  int mwait = 0;

  rr_bus_arbiter_if #(.MASTER_CNT(N)) bus ();

  rr_bus_arbiter #(
    .MASTER_CNT (N),
    .TIMEOUT_CYC(TO),
    .ERR_RDATA  (ERR)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .currmaster (currmaster),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : model
    logic [3:0]   e_rdy;
    logic [127:0] e_rd;
    logic [31:0]  e_addr, e_wd, e_cm;
    logic [3:0]   e_ws;
    logic         e_sv, e_to;
    bit           tout;
    e_rdy = '0; e_rd = '0; e_addr = '0; e_wd = '0; e_ws = '0;
    e_sv = 1'b0; e_to = 1'b0; e_cm = '0;
    if (!resetn) begin
      mbusy = 1'b0; mg = 0; mlast = N - 1; mwait = 0;
    end else begin
      e_cm = 32'(mg);
      if (mbusy) begin
        e_addr = bus.m_addr[32*mg +: 32];
        e_wd   = bus.m_wdata[32*mg +: 32];
        e_ws   = bus.m_wstrb[4*mg +: 4];
        if (bus.m_valid[mg]) begin
          tout = (mwait == TO) && !bus.s_ready;
          e_sv = !tout;
          e_rd[32*mg +: 32] = tout ? ERR : bus.s_rdata;
          if (bus.s_ready || tout) begin
            e_rdy[mg] = 1'b1;
            e_to      = tout;
            mlast     = mg;
            mbusy     = 1'b0;
          end else begin
            mwait++;
          end
        end else begin
          e_rd[32*mg +: 32] = bus.s_rdata;
          mbusy = 1'b0;
        end
      end else if (bus.m_valid != 0) begin
        for (int k = 1; k <= N; k++) begin
          if (!mbusy && bus.m_valid[(mlast + k) % N]) begin
            mg    = (mlast + k) % N;
            mbusy = 1'b1;
          end
        end
        mwait = 0;
      end
    end
    chk("s_valid", 128'(bus.s_valid), 128'(e_sv));
    chk("s_addr", 128'(bus.s_addr), 128'(e_addr));
    chk("s_wdata", 128'(bus.s_wdata), 128'(e_wd));
    chk("s_wstrb", 128'(bus.s_wstrb), 128'(e_ws));
    chk("m_ready", 128'(bus.m_ready), 128'(e_rdy));
    chk("m_rdata", bus.m_rdata, e_rd);
    chk("currmaster", 128'(currmaster), 128'(e_cm));
    chk("timeout_err", 128'(timeout_err), 128'(e_to));
    for (int i = 0; i < N; i++) if (bus.m_ready[i]) served.push_back(i);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    bus.m_valid = '0;
    bus.s_ready = 1'b0;
    step();
    step();
    resetn = 1'b1;
    served.delete();
  endtask

  initial begin
    int n;
    bus.m_valid = '0;
    bus.s_ready = 1'b0;
    bus.s_rdata = '0;
    for (int i = 0; i < N; i++) begin
      bus.m_addr[32*i +: 32]  = 32'h1000_0000 + 32'(i * 16);
      bus.m_wdata[32*i +: 32] = 32'hA5A5_0000 | 32'(i);
      bus.m_wstrb[4*i +: 4]   = (i % 2 == 0) ? 4'(4'hF >> i) : 4'h0;
    end

    // Reset state
    #1;
    chk("rst_s_valid", 128'(bus.s_valid), 128'(0));
    chk("rst_m_ready", 128'(bus.m_ready), 128'(0));
    chk("rst_currmaster", 128'(currmaster), 128'(0));
    chk("rst_timeout_err", 128'(timeout_err), 128'(0));

    // Single request from master 2, slave ready immediately
    do_reset();
    bus.s_ready = 1'b1;
    bus.s_rdata = 32'h1234_5678;
    bus.m_valid = 4'b0100;
    step();
    chk("single_m_ready", 128'(bus.m_ready), 128'(4'b0100));
    chk("single_currmaster", 128'(currmaster), 128'(2));
    chk("single_rdata2", 128'(bus.m_rdata[95:64]), 128'(32'h1234_5678));
    chk("single_s_addr", 128'(bus.s_addr), 128'(32'h1000_0020));
    chk("single_s_wstrb", 128'(bus.s_wstrb), 128'(4'h3));
    bus.m_valid = '0;
    step();

    // Full rotation with all masters requesting
    do_reset();
    bus.s_ready = 1'b1;
    bus.m_valid = 4'b1111;
    repeat (10) step();
    bus.m_valid = '0;
    step();
    chk("rot_count", 128'(served.size()), 128'(5));
    if (served.size() == 5) begin
      chk("rot_0", 128'(served[0]), 128'(0));
      chk("rot_1", 128'(served[1]), 128'(1));
      chk("rot_2", 128'(served[2]), 128'(2));
      chk("rot_3", 128'(served[3]), 128'(3));
      chk("rot_4", 128'(served[4]), 128'(0));
    end

    // Skip with wrap: last=2, then masters 0 and 1 request
    do_reset();
    bus.s_ready = 1'b1;
    bus.m_valid = 4'b0100;
    step();
    step();
    bus.m_valid = 4'b0011;
    repeat (4) step();
    bus.m_valid = '0;
    step();
    chk("wrap_count", 128'(served.size()), 128'(3));
    if (served.size() == 3) begin
      chk("wrap_first", 128'(served[1]), 128'(0));
      chk("wrap_second", 128'(served[2]), 128'(1));
    end

    // Timeout with slave stuck, then next requester served
    do_reset();
    bus.s_ready = 1'b0;
    bus.s_rdata = 32'h55AA_55AA;
    bus.m_valid = 4'b0011;
    n = 0;
    while (bus.m_ready == 0 && n < 30) begin
      step();
      n++;
    end
    chk("to_latency", 128'(n), 128'(9));
    chk("to_m_ready", 128'(bus.m_ready), 128'(4'b0001));
    chk("to_err_pulse", 128'(timeout_err), 128'(1));
    chk("to_rdata0", 128'(bus.m_rdata[31:0]), 128'(32'hDEADBEEF));
    chk("to_s_valid", 128'(bus.s_valid), 128'(0));
    step();
    chk("to_err_clear", 128'(timeout_err), 128'(0));
    bus.s_ready = 1'b1;
    bus.s_rdata = 32'h0BAD_F00D;
    step();
    chk("to_next_ready", 128'(bus.m_ready), 128'(4'b0010));
    chk("to_next_gnt", 128'(currmaster), 128'(1));
    chk("to_next_rdata1", 128'(bus.m_rdata[63:32]), 128'(32'h0BAD_F00D));
    step();
    bus.m_valid = '0;
    step();

    // s_ready arrives in the same cycle the counter reaches the limit
    do_reset();
    bus.s_ready = 1'b0;
    bus.m_valid = 4'b0001;
    repeat (9) step();
    bus.s_ready = 1'b1;
    bus.s_rdata = 32'hC0FF_EE01;
    #1;
    chk("coin_m_ready", 128'(bus.m_ready), 128'(4'b0001));
    chk("coin_no_err", 128'(timeout_err), 128'(0));
    chk("coin_rdata0", 128'(bus.m_rdata[31:0]), 128'(32'hC0FF_EE01));
    step();
    bus.m_valid = '0;
    step();

    // Reset while master 3 holds the bus
    do_reset();
    bus.s_ready = 1'b0;
    bus.m_valid = 4'b1000;
    step();
    chk("rstmid_gnt", 128'(currmaster), 128'(3));
    chk("rstmid_s_valid_before", 128'(bus.s_valid), 128'(1));
    resetn = 1'b0;
    #1;
    chk("rstmid_s_valid", 128'(bus.s_valid), 128'(0));
    chk("rstmid_m_ready", 128'(bus.m_ready), 128'(0));
    step();
    resetn      = 1'b1;
    bus.m_valid = 4'b1001;
    bus.s_ready = 1'b1;
    step();
    chk("rstmid_first_gnt", 128'(currmaster), 128'(0));
    chk("rstmid_first_ready", 128'(bus.m_ready), 128'(4'b0001));
    step();
    bus.m_valid = '0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rr_bus_arbiter.md
RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

Interface
REQ-001 SHALL have parameter MASTER_CNT, default 4, number of bus masters (1..16).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, slave-wait cycles before error completion; 0 disables the timeout.
REQ-003 SHALL have parameter ERR_RDATA, default 32'hDEADBEEF, read data returned on a timeout completion.
REQ-004 SHALL have a single clock and an asynchronous, active-low reset: clk (in, 1, rising-edge clock) and resetn (in, 1, async active-low reset).
REQ-005 SHALL have m_valid (in, MASTER_CNT): per-master request.
REQ-006 SHALL have m_addr (in, 32*MASTER_CNT): per-master address, master i in bits [32*i+:32].
REQ-007 SHALL have m_wdata (in, 32*MASTER_CNT): per-master write data, same slicing as m_addr.
REQ-008 SHALL have m_wstrb (in, 4*MASTER_CNT): per-master byte write strobes, 0 = read.
REQ-009 SHALL have m_ready (out, MASTER_CNT): per-master completion pulse.
REQ-010 SHALL have m_rdata (out, 32*MASTER_CNT): per-master read data.
REQ-011 SHALL have the slave-side request signals s_valid (out, 1), s_addr (out, 32), s_wdata (out, 32) and s_wstrb (out, 4).
REQ-012 SHALL have the slave-side response signals s_ready (in, 1) and s_rdata (in, 32).
REQ-013 SHALL have currmaster (out, 32): index of the granted master, zero-extended.
REQ-014 SHALL have timeout_err (out, 1): one-cycle pulse on a timeout completion.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and BUSY, plus a grant index register gnt and a last-served register last.
REQ-016 SHALL, in IDLE with any m_valid set, load gnt with the first set bit searching upward from (last+1) mod MASTER_CNT with wrap, then go to BUSY.
REQ-017 SHALL, in IDLE with no m_valid set, stay in IDLE and hold gnt.
REQ-018 SHALL, in BUSY, drive s_valid = m_valid[gnt] and pass m_addr, m_wdata and m_wstrb of master gnt combinationally to s_addr, s_wdata and s_wstrb.
REQ-019 SHALL, in IDLE, drive s_valid=0, s_addr=0, s_wdata=0 and s_wstrb=0.
REQ-020 SHALL, in BUSY with s_valid and s_ready both high, assert m_ready[gnt] in that same cycle, set last<=gnt and go to IDLE.
REQ-021 SHALL route s_rdata to m_rdata slice gnt in BUSY and drive all other m_rdata slices to 0.
REQ-022 SHALL give a minimum latency of 2 cycles from m_valid rising to m_ready: one IDLE cycle, then a BUSY cycle with immediate s_ready.
REQ-023 SHALL return to IDLE without updating last and without any m_ready if m_valid[gnt] drops while in BUSY.
REQ-024 SHALL run a wait counter in BUSY: cleared on entry, incremented each BUSY cycle while s_ready is low, and sized for TIMEOUT_CYC.
REQ-025 SHALL, when TIMEOUT_CYC != 0 and the counter equals TIMEOUT_CYC with s_ready low, in that cycle: assert m_ready[gnt], force m_rdata slice gnt to ERR_RDATA, deassert s_valid, pulse timeout_err, set last<=gnt and go to IDLE.
REQ-026 SHALL give s_ready priority over the timeout when both occur in the same cycle (normal completion, no timeout_err).
REQ-027 SHALL ignore s_ready while in IDLE.
REQ-028 SHALL assert m_ready for at most one master per cycle, and only in BUSY.
REQ-029 SHALL, with MASTER_CNT=1, always grant master 0 and keep all other behaviour unchanged.
REQ-030 SHALL never preempt a granted master, so that new requests arriving during BUSY wait for IDLE.
REQ-031 SHALL make fairness strict rotation, so that with all masters requesting continuously each master is served once every MASTER_CNT transactions.

Reset
REQ-032 SHALL, on resetn low, asynchronously force state=IDLE, gnt=0, last=MASTER_CNT-1, wait counter=0, m_ready=0 and timeout_err=0.
REQ-033 SHALL abort any in-flight transaction on reset with no m_ready, so that s_valid drops immediately.
REQ-034 SHALL make the first grant after reset go to the lowest-index requesting master.

Verification
REQ-035 SHALL cover single request: MASTER_CNT=4, m_valid=0100, s_ready high at first BUSY cycle -> m_ready=0100 on 2nd cycle, currmaster=2, s_rdata=0x12345678 appears on slice 2.
REQ-036 SHALL cover rotation: m_valid=1111 held, s_ready always 1 -> grant order 0,1,2,3,0, one m_ready pulse every 2 cycles.
REQ-037 SHALL cover skip with wrap: last=2, m_valid=0011 -> gnt=0, then gnt=1.
REQ-038 SHALL cover timeout: TIMEOUT_CYC=8, s_ready stuck 0 -> m_ready pulses after 8 waiting BUSY cycles, m_rdata=0xDEADBEEF, timeout_err one cycle, the next requester is granted afterwards.
REQ-039 SHALL cover the coincident edge: s_ready rises in the same cycle the counter hits TIMEOUT_CYC -> s_rdata is returned and timeout_err stays 0.
REQ-040 SHALL cover reset mid-transaction: resetn low in BUSY with gnt=3 -> s_valid=0 immediately with no m_ready, and after release m_valid=1001 grants master 0.
